pulse_period_meter: RTL and testbench

- Receive-side counterpart of the tick/prescaler generators in the accumulator path.
- Takes a pulse train (for example a heartbeat or a divided PLL tick), synchronises it, detects rising edges and measures the clk-cycle period between successive edges.
- Reports each measurement with a one-cycle valid strobe, flags timeouts, and declares lock once the period is stable.

---
 rtl/pulse_period_meter.sv | 143 ++++++++++++++
 tb/tb_pulse_period_meter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle period between rising edges of an asynchronous pulse train,
// with a timeout strobe and a lock indication once consecutive periods agree.
//
// Output strobes: period_valid and timeout are single-cycle, registered, mutually
// exclusive pulses; there is no backpressure (no ready), consumers must sample them
// in the cycle they are high. period and locked are levels that hold between strobes.
module pulse_period_meter #(
    parameter int MAX_COUNT   = 100000000,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_N      = 4,
    parameter int TOL         = 0,
    localparam int CW         = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          pulse_in,
    output logic [CW-1:0] period,
    output logic          period_valid,
    output logic          timeout,
    output logic          locked,
    output logic [1:0]    fsm_state
);

    localparam int MW      = $clog2(LOCK_N + 1);
    localparam int TOL_SAT = (TOL > MAX_COUNT) ? MAX_COUNT : TOL;

    localparam logic [CW-1:0] LIMIT = CW'(MAX_COUNT - 1);
    localparam logic [CW-1:0] TOL_C = CW'(TOL_SAT);
    localparam logic [MW-1:0] LOCK_C = MW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_prev;
    logic                   rise;
    logic [CW-1:0]          cnt;
    logic [MW-1:0]          match_cnt;
    logic                   seeded;

    logic [CW-1:0]          new_period;
    logic [CW-1:0]          diff;
    logic                   in_tol;
    logic                   at_limit;
    logic [MW-1:0]          match_inc;

    // The synchroniser runs regardless of enable so edge history is never stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff   <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[SYNC_STAGES-2:0], pulse_in};
            sync_prev <= sync_ff[SYNC_STAGES-1];
        end
    end

    assign rise = sync_ff[SYNC_STAGES-1] & ~sync_prev;

    assign new_period = cnt + CW'(1);
    assign diff       = (new_period >= period) ? (new_period - period) : (period - new_period);
    assign in_tol     = (diff <= TOL_C);
    assign at_limit   = (cnt == LIMIT);
    assign match_inc  = (match_cnt == LOCK_C) ? match_cnt : match_cnt + MW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= '0;
            seeded       <= 1'b0;
            period       <= '0;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            locked       <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            if (!enable) begin
                state     <= IDLE;
                cnt       <= '0;
                match_cnt <= '0;
                seeded    <= 1'b0;
                locked    <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt    <= '0;
                        locked <= 1'b0;
                        state  <= WAIT_FIRST;
                    end
                    WAIT_FIRST: begin
                        cnt    <= '0;
                        seeded <= 1'b0;
                        if (rise) begin
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        // An edge on the last count wins over the timeout.
                        if (rise) begin
                            period       <= new_period;
                            period_valid <= 1'b1;
                            cnt          <= '0;
                            seeded       <= 1'b1;
                            if (seeded) begin
                                if (in_tol) begin
                                    match_cnt <= match_inc;
                                    if (match_inc == LOCK_C) begin
                                        locked <= 1'b1;
                                    end
                                end else begin
                                    match_cnt <= '0;
                                    locked    <= 1'b0;
                                end
                            end
                        end else if (at_limit) begin
                            timeout   <= 1'b1;
                            locked    <= 1'b0;
                            match_cnt <= '0;
                            seeded    <= 1'b0;
                            cnt       <= '0;
                            state     <= WAIT_FIRST;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Bench for pulse_period_meter: directed table of pulse intervals, reset/enable
// sequences, and random pulse trains, all checked against a timestamp-based model.
module tb_pulse_period_meter;

    localparam int MAX_COUNT   = 16;
    localparam int SYNC_STAGES = 2;
    localparam int LOCK_N      = 3;
    localparam int TOL         = 0;
    localparam int CW          = $clog2(MAX_COUNT + 1);
    localparam int NROWS       = 19;
    localparam int LOGN        = 1024;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          pulse_in = 1'b0;
    logic [CW-1:0] period;
    logic          period_valid;
    logic          timeout;
    logic          locked;
    logic [1:0]    fsm_state;

    pulse_period_meter #(
        .MAX_COUNT  (MAX_COUNT),
        .SYNC_STAGES(SYNC_STAGES),
        .LOCK_N     (LOCK_N),
        .TOL        (TOL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pulse_in    (pulse_in),
        .period      (period),
        .period_valid(period_valid),
        .timeout     (timeout),
        .locked      (locked),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_valid_seen = 0;

    // Reference model: mode 0 = disabled, 1 = waiting for window-opening edge,
    // 2 = timing since m_last (cycle index of the last detected edge).
    int m_mode, m_last, m_period, m_matches;
    bit m_valid, m_to, m_locked, m_seeded;
    bit samp_q[$];

    bit log_v[LOGN];
    bit log_t[LOGN];
    bit log_l[LOGN];
    int log_p[LOGN];

    typedef struct {
        int gap;
        int width;
        int n_valid;
        int n_to;
        int per;
        bit lk;
    } row_t;

    row_t tbl[NROWS];
    int   row_rise[NROWS];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_tick();
        bit e;
        int elapsed;
        int d;
        m_valid = 1'b0;
        m_to    = 1'b0;
        if (rst) begin
            samp_q = {};
            for (int i = 0; i <= SYNC_STAGES; i++) samp_q.push_back(1'b0);
            m_mode = 0; m_last = 0; m_period = 0; m_matches = 0;
            m_locked = 1'b0; m_seeded = 1'b0;
        end else begin
            // Edge seen now comes from samples taken SYNC_STAGES and SYNC_STAGES+1 posedges ago.
            e = samp_q[1] && !samp_q[0];
            samp_q.push_back(pulse_in);
            void'(samp_q.pop_front());
            if (!enable) begin
                m_mode = 0; m_matches = 0; m_locked = 1'b0; m_seeded = 1'b0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (e) begin
                    m_mode = 2;
                    m_last = cyc;
                end
            end else begin
                elapsed = cyc - m_last;
                if (e) begin
                    if (m_seeded) begin
                        d = (elapsed > m_period) ? elapsed - m_period : m_period - elapsed;
                        if (d <= TOL) begin
                            if (m_matches < LOCK_N) m_matches++;
                            if (m_matches == LOCK_N) m_locked = 1'b1;
                        end else begin
                            m_matches = 0;
                            m_locked  = 1'b0;
                        end
                    end
                    m_seeded = 1'b1;
                    m_period = elapsed;
                    m_valid  = 1'b1;
                    m_last   = cyc;
                end else if (elapsed == MAX_COUNT) begin
                    m_to = 1'b1; m_mode = 1; m_locked = 1'b0; m_matches = 0; m_seeded = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic p, input logic en, input logic r);
        @(negedge clk);
        pulse_in = p;
        enable   = en;
        rst      = r;
        #1;
        if (rst) begin
            chk("async_rst_period", int'(period), 0);
            chk("async_rst_valid", int'(period_valid), 0);
            chk("async_rst_locked", int'(locked), 0);
        end
        @(posedge clk);
        cyc++;
        model_tick();
        #1;
        chk("period", int'(period), m_period);
        chk("period_valid", int'(period_valid), int'(m_valid));
        chk("timeout", int'(timeout), int'(m_to));
        chk("locked", int'(locked), int'(m_locked));
        chk("fsm_state_legal", int'(fsm_state == 2'd3), 0);
        if (period_valid) n_valid_seen++;
        if (cyc < LOGN) begin
            log_v[cyc] = period_valid;
            log_t[cyc] = timeout;
            log_l[cyc] = locked;
            log_p[cyc] = int'(period);
        end
    endtask

    task automatic pulses(input int n, input int gap, input int width);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < gap; k++) step(k < width, 1'b1, 1'b0);
    endtask

    initial begin
        int nv, nt, last, snap, gap, width;

        // gap, width, strobes, timeouts, period and locked at window end
        tbl[0]  = '{4, 1, 0, 0, 0, 1'b0};
        tbl[1]  = '{4, 1, 1, 0, 4, 1'b0};
        tbl[2]  = '{4, 1, 1, 0, 4, 1'b0};
        tbl[3]  = '{4, 1, 1, 0, 4, 1'b0};
        tbl[4]  = '{6, 1, 1, 0, 4, 1'b1};
        tbl[5]  = '{20, 1, 1, 1, 6, 1'b0};
        tbl[6]  = '{5, 1, 0, 0, 6, 1'b0};
        tbl[7]  = '{16, 1, 1, 0, 5, 1'b0};
        tbl[8]  = '{16, 1, 1, 0, 16, 1'b0};
        tbl[9]  = '{16, 1, 1, 0, 16, 1'b0};
        tbl[10] = '{17, 1, 1, 1, 16, 1'b0};
        tbl[11] = '{17, 1, 0, 1, 16, 1'b0};
        tbl[12] = '{17, 1, 0, 1, 16, 1'b0};
        tbl[13] = '{12, 10, 0, 0, 16, 1'b0};
        tbl[14] = '{12, 10, 1, 0, 12, 1'b0};
        tbl[15] = '{12, 10, 1, 0, 12, 1'b0};
        tbl[16] = '{12, 10, 1, 0, 12, 1'b0};
        tbl[17] = '{12, 10, 1, 0, 12, 1'b1};
        tbl[18] = '{12, 1, 1, 0, 12, 1'b1};

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        chk("reset_period", int'(period), 0);
        chk("reset_locked", int'(locked), 0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        for (int i = 0; i < NROWS; i++) begin
            row_rise[i] = cyc + 1;
            for (int k = 0; k < tbl[i].gap; k++) step(k < tbl[i].width, 1'b1, 1'b0);
        end
        for (int i = 0; i < SYNC_STAGES; i++) step(1'b0, 1'b1, 1'b0);

        // Each row's window starts when its own edge reaches the FSM.
        for (int i = 0; i < NROWS; i++) begin
            nv = 0;
            nt = 0;
            for (int c = row_rise[i] + SYNC_STAGES; c < row_rise[i] + tbl[i].gap + SYNC_STAGES; c++) begin
                nv += int'(log_v[c]);
                nt += int'(log_t[c]);
            end
            last = row_rise[i] + tbl[i].gap + SYNC_STAGES - 1;
            chk($sformatf("row%0d_strobes", i), nv, tbl[i].n_valid);
            chk($sformatf("row%0d_timeouts", i), nt, tbl[i].n_to);
            chk($sformatf("row%0d_period", i), log_p[last], tbl[i].per);
            chk($sformatf("row%0d_locked", i), int'(log_l[last]), int'(tbl[i].lk));
        end

        // Reset halfway through a locked period, then restart.
        pulses(6, 4, 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("rst_mid_period", int'(period), 0);
        snap = n_valid_seen;
        pulses(3, 7, 1);
        for (int i = 0; i < SYNC_STAGES; i++) step(1'b0, 1'b1, 1'b0);
        chk("rst_restart_strobes", n_valid_seen - snap, 2);
        chk("rst_restart_period", int'(period), 7);

        // Enable dropped halfway through a locked period.
        pulses(6, 5, 1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        snap = n_valid_seen;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        chk("en_low_period_held", int'(period), 5);
        chk("en_low_locked", int'(locked), 0);
        chk("en_low_no_strobe", n_valid_seen - snap, 0);
        snap = n_valid_seen;
        pulses(3, 9, 1);
        for (int i = 0; i < SYNC_STAGES; i++) step(1'b0, 1'b1, 1'b0);
        chk("en_restart_strobes", n_valid_seen - snap, 2);
        chk("en_restart_period", int'(period), 9);

        // Random pulse trains with occasional enable drops and resets.
        for (int i = 0; i < 250; i++) begin
            gap   = $urandom_range(2, 22);
            width = $urandom_range(1, gap - 1);
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++) step(1'b0, 1'b0, 1'b0);
            end
            if ($urandom_range(0, 79) == 0) step(1'b0, 1'b1, 1'b1);
            if ($urandom_range(0, 3) == 0) gap = 4;
            for (int k = 0; k < gap; k++) step(k < width, 1'b1, 1'b0);
        end
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
